// File: rtl/sorted_vec_serializer.sv
// Turns one packed sorted vector into a valid/ready element stream, index 0 first.
// Define SORT_CHECK_EN to add the monotonic-order checker (sort_err pulse, err_cnt).
module sorted_vec_serializer #(
  parameter int DATA_W    = 8,
  parameter int DATA_N    = 7,
  parameter int ORDER_ASC = 1,
  localparam int IW       = (DATA_N > 1) ? $clog2(DATA_N) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     vec_valid,
  output logic                     vec_ready,
  input  logic [DATA_N*DATA_W-1:0] vec_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [IW-1:0]            out_idx,
  output logic                     out_last,
  output logic                     sort_err,
  output logic [15:0]              err_cnt
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_N - 1);

  state_t            state, state_next;
  logic [IW-1:0]     idx, idx_next;
  logic [DATA_W-1:0] vec_buf [DATA_N];
  logic              load;
  logic              fire;

  // Order predicate on unsigned elements; equal values never violate.
  function automatic logic order_viol(input logic [DATA_W-1:0] prev,
                                      input logic [DATA_W-1:0] cur);
    return (ORDER_ASC != 0) ? (prev > cur) : (prev < cur);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      for (int i = 0; i < DATA_N; i++) vec_buf[i] <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      if (load) begin
        for (int i = 0; i < DATA_N; i++) vec_buf[i] <= vec_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // A vector offered during the last beat is taken in the same cycle, so the
  // stream continues without a bubble.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    load       = 1'b0;
    vec_ready  = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    case (state)
      IDLE: begin
        vec_ready = 1'b1;
        if (vec_valid) begin
          load       = 1'b1;
          idx_next   = '0;
          state_next = SEND;
        end
      end
      SEND: begin
        out_valid = 1'b1;
        out_last  = (idx == LAST_IDX);
        if (out_ready) begin
          if (idx == LAST_IDX) begin
            vec_ready = 1'b1;
            idx_next  = '0;
            if (vec_valid) load = 1'b1;
            else           state_next = IDLE;
          end else begin
            idx_next = idx + IW'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign fire     = out_valid & out_ready;
  assign out_data = out_valid ? vec_buf[idx] : '0;
  assign out_idx  = idx;

`ifdef SORT_CHECK_EN
  logic [DATA_W-1:0] prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev     <= '0;
      sort_err <= 1'b0;
      err_cnt  <= '0;
    end else begin
      sort_err <= 1'b0;
      if (fire) begin
        prev <= out_data;
        // idx 0 starts a new vector: no comparison across vectors.
        if ((idx != '0) && order_viol(prev, out_data)) begin
          sort_err <= 1'b1;
          if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        end
      end
    end
  end
`else
  assign sort_err = 1'b0;
  assign err_cnt  = '0;
`endif

endmodule

// File: tb/tb_sorted_vec_serializer.sv
// Scoreboard bench for sorted_vec_serializer: a DATA_N=7 instance and a DATA_N=1 instance.
module tb_sorted_vec_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vec_valid, vec_ready, out_valid, out_ready, out_last, sort_err;
  logic [55:0] vec_data;
  logic [7:0]  out_data;
  logic [2:0]  out_idx;
  logic [15:0] err_cnt;

  logic        d1_vec_valid, d1_vec_ready, d1_out_valid, d1_out_ready, d1_out_last, d1_sort_err;
  logic [7:0]  d1_vec_data, d1_out_data;
  logic [0:0]  d1_out_idx;
  logic [15:0] d1_err_cnt;

  always #5 clk = ~clk;

  sorted_vec_serializer #(.DATA_W(8), .DATA_N(7), .ORDER_ASC(1)) dut (
    .clk(clk), .rst_n(rst_n), .vec_valid(vec_valid), .vec_ready(vec_ready),
    .vec_data(vec_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
    .sort_err(sort_err), .err_cnt(err_cnt));

  sorted_vec_serializer #(.DATA_W(8), .DATA_N(1), .ORDER_ASC(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .vec_valid(d1_vec_valid), .vec_ready(d1_vec_ready),
    .vec_data(d1_vec_data), .out_valid(d1_out_valid), .out_ready(d1_out_ready),
    .out_data(d1_out_data), .out_idx(d1_out_idx), .out_last(d1_out_last),
    .sort_err(d1_sort_err), .err_cnt(d1_err_cnt));

`ifdef SORT_CHECK_EN
  localparam int EXP_ERRS_T5 = 2;
  localparam bit CHECK_ON    = 1'b1;
`else
  localparam int EXP_ERRS_T5 = 0;
  localparam bit CHECK_ON    = 1'b0;
`endif

  typedef struct {
    logic [7:0] data;
    logic [2:0] idx;
    logic       last;
  } beat_t;

  beat_t       q[$];
  logic [7:0]  q1[$];
  int          total = 0;
  int          bad   = 0;
  int          fired = 0;
  int          cyc   = 0;
  int          fire_cyc[$];
  logic        exp_err_pend = 1'b0;
  logic [7:0]  m_prev = 8'd0;
  logic        hold_pend = 1'b0;
  logic [7:0]  hold_data;
  logic [2:0]  hold_idx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Main-instance monitor: pops the scoreboard on every fired beat.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_err_pend = 1'b0;
      hold_pend    = 1'b0;
    end else begin
      check("sort_err", 32'(sort_err), 32'(exp_err_pend));
      exp_err_pend = 1'b0;
      if (hold_pend) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(hold_data));
        check("hold_idx", 32'(out_idx), 32'(hold_idx));
      end
      if (out_valid && !(out_last && out_ready))
        check("vec_ready_in_send", 32'(vec_ready), 32'd0);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got data %0h idx %0d with empty scoreboard", out_data, out_idx);
        end else begin
          beat_t b;
          b = q.pop_front();
          check("beat_data", 32'(out_data), 32'(b.data));
          check("beat_idx", 32'(out_idx), 32'(b.idx));
          check("beat_last", 32'(out_last), 32'(b.last));
          if (CHECK_ON && b.idx != 3'd0 && m_prev > b.data) exp_err_pend = 1'b1;
          m_prev = b.data;
          fired++;
          fire_cyc.push_back(cyc);
        end
      end
      hold_pend = out_valid && !out_ready;
      hold_data = out_data;
      hold_idx  = out_idx;
    end
  end

  // DATA_N=1 monitor.
  always @(negedge clk) begin
    if (rst_n && d1_out_valid && d1_out_ready) begin
      if (q1.size() == 0) begin
        total++;
        bad++;
        $display("FAIL d1_unexpected_beat: got data %0h with empty scoreboard", d1_out_data);
      end else begin
        logic [7:0] e;
        e = q1.pop_front();
        check("d1_data", 32'(d1_out_data), 32'(e));
        check("d1_idx", 32'(d1_out_idx), 32'd0);
        check("d1_last", 32'(d1_out_last), 32'd1);
      end
    end
  end

  task automatic send_vec(input logic [7:0] e [7], input bit keep_valid);
    int n = 0;
    for (int i = 0; i < 7; i++) vec_data[i*8 +: 8] = e[i];
    vec_valid = 1'b1;
    @(negedge clk);
    while (!vec_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("vec_accept_timeout", 32'(vec_ready), 32'd1);
    for (int i = 0; i < 7; i++) q.push_back('{e[i], 3'(i), (i == 6)});
    @(posedge clk);
    #1;
    if (!keep_valid) vec_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    check("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  task automatic send1(input logic [7:0] d);
    int n = 0;
    d1_vec_data  = d;
    d1_vec_valid = 1'b1;
    @(negedge clk);
    while (!d1_vec_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("d1_accept_timeout", 32'(d1_vec_ready), 32'd1);
    q1.push_back(d);
    @(posedge clk);
    #1;
    d1_vec_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] va [7];
    logic [7:0] vb [7];
    logic [1:0] pat [4];
    int base, n;

    rst_n        = 1'b0;
    vec_valid    = 1'b0;
    vec_data     = '0;
    out_ready    = 1'b1;
    d1_vec_valid = 1'b0;
    d1_vec_data  = '0;
    d1_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_idx", 32'(out_idx), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_sort_err", 32'(sort_err), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_vec_ready", 32'(vec_ready), 32'd1);

    // 1: basic serialization, latency 1, consecutive beats
    va = '{8'd3, 8'd5, 8'd9, 8'd9, 8'd20, 8'd40, 8'd200};
    base = fire_cyc.size();
    send_vec(va, 1'b0);
    check("t1_latency_valid", 32'(out_valid), 32'd1);
    check("t1_first_data", 32'(out_data), 32'd3);
    wait_drain();
    check("t1_beats", 32'(fire_cyc.size() - base), 32'd7);
    if (fire_cyc.size() - base == 7)
      check("t1_consecutive", 32'(fire_cyc[base+6] - fire_cyc[base]), 32'd6);
    check("t1_idle_after", 32'(out_valid), 32'd0);

    // 2: out_ready stalls 1,0,0,1,...
    pat = '{2'd1, 2'd0, 2'd0, 2'd1};
    base = fired;
    send_vec(va, 1'b0);
    n = 0;
    while (q.size() != 0 && n < 100) begin
      out_ready = pat[n % 4][0];
      @(posedge clk);
      #1;
      n++;
    end
    out_ready = 1'b1;
    wait_drain();
    check("t2_beats", 32'(fired - base), 32'd7);
    check("t2_idle_after", 32'(out_valid), 32'd0);

    // 3: back-to-back vectors, zero bubble
    vb = '{8'd0, 8'd1, 8'd2, 8'd100, 8'd101, 8'd254, 8'd255};
    base = fire_cyc.size();
    send_vec(va, 1'b1);
    send_vec(vb, 1'b0);
    wait_drain();
    check("t3_beats", 32'(fire_cyc.size() - base), 32'd14);
    if (fire_cyc.size() - base == 14)
      check("t3_consecutive", 32'(fire_cyc[base+13] - fire_cyc[base]), 32'd13);

    // 4: asynchronous reset mid-vector after three beats
    base = fired;
    send_vec(va, 1'b0);
    n = 0;
    while (fired < base + 3 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("t4_three_beats", 32'(fired - base), 32'd3);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t4_rst_valid", 32'(out_valid), 32'd0);
    check("t4_rst_data", 32'(out_data), 32'd0);
    check("t4_rst_idx", 32'(out_idx), 32'd0);
    check("t4_rst_last", 32'(out_last), 32'd0);
    q.delete();
    m_prev = 8'd0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      check("t4_post_ready", 32'(vec_ready), 32'd1);
      check("t4_post_valid", 32'(out_valid), 32'd0);
    end
    check("t4_no_extra_beats", 32'(fired - base), 32'd3);

    // 5: order checker ({1,2,7,4,8,8,3} violates at idx3 and idx6)
    va = '{8'd1, 8'd2, 8'd7, 8'd4, 8'd8, 8'd8, 8'd3};
    send_vec(va, 1'b0);
    wait_drain();
    @(posedge clk);
    #1;
    check("t5_err_cnt", 32'(err_cnt), 32'(EXP_ERRS_T5));
    vb = '{8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5};
    send_vec(vb, 1'b0);
    wait_drain();
    @(posedge clk);
    #1;
    check("t5_err_cnt_equal", 32'(err_cnt), 32'(EXP_ERRS_T5));

    // 6: DATA_N=1 instance
    check("t6_d1_idle_ready", 32'(d1_vec_ready), 32'd1);
    send1(8'h5A);
    send1(8'hA5);
    send1(8'h5A);
    n = 0;
    while (q1.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    check("t6_d1_drain", 32'(q1.size()), 32'd0);
    check("t6_d1_idle", 32'(d1_out_valid), 32'd0);
    check("t6_d1_err_cnt", 32'(d1_err_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
